// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and TX FSM state encodings for the UART buffer
`timescale 1ns/1ps
package uart_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; push while full is accepted only alongside a pop
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push, w_pop;
   assign w_pop   = i_pop & (r_count != '0);
   assign w_push  = i_push & ((r_count != (AW+1)'(DEPTH)) | w_pop);
   assign o_empty = r_count == '0;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_count = r_count;
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
   // storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   // pointers wrap naturally at power-of-two depth; count tracks occupancy
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
endmodule

// File: rtl/uart_io_buffer.sv
// uart_io_buffer: RX/TX byte FIFOs between the uart and the core's ,/. logic
`timescale 1ns/1ps
module uart_io_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] uart_data_rx,
   input  logic              uart_receive_done,
   output logic [BYTE_W-1:0] uart_data_tx,
   output logic              uart_start_transmit,
   input  logic              uart_tx_ready,
   output logic [BYTE_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              rx_overflow,
   output logic              tx_idle
);
   logic                    r_rx_done_d, r_rx_push;
   logic [BYTE_W-1:0]       r_rx_byte;
   tx_state_t               r_state;
   logic                    w_rx_full, w_rx_empty, w_rd_pop;
   logic [$clog2(DEPTH):0]  w_rx_count, w_tx_count;
   logic                    w_tx_full, w_tx_empty, w_tx_pop, w_tx_push;
   logic [BYTE_W-1:0]       w_tx_head;
   assign w_rd_pop  = rd_ready & (w_rx_count != '0);
   assign rd_valid  = ~w_rx_empty;
   assign wr_ready  = ~w_tx_full;
   assign w_tx_push = wr_valid & ~w_tx_full;
   assign w_tx_pop  = (r_state == IDLE) & ~w_tx_empty & uart_tx_ready;
   assign tx_idle   = (w_tx_count == '0) & (r_state == IDLE) & uart_tx_ready;
   sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .i_push(r_rx_push), .i_din(r_rx_byte), .i_pop(w_rd_pop),
      .o_dout(rd_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
   );
   sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .i_push(w_tx_push), .i_din(wr_data), .i_pop(w_tx_pop),
      .o_dout(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
   );
   // receive_done rising edge becomes a one-cycle registered push; a drop while full sets the sticky flag
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_rx_done_d <= 1'b0;
         r_rx_push   <= 1'b0;
         r_rx_byte   <= '0;
         rx_overflow <= 1'b0;
      end else begin
         r_rx_done_d <= uart_receive_done;
         r_rx_push   <= uart_receive_done & ~r_rx_done_d;
         r_rx_byte   <= uart_data_rx;
         if (r_rx_push & w_rx_full & ~w_rd_pop) rx_overflow <= 1'b1;
      end
   // TX FSM: load a byte, pulse start once, then follow tx_ready low and back high
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state             <= IDLE;
         uart_data_tx        <= '0;
         uart_start_transmit <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (w_tx_pop) begin
                  uart_data_tx        <= w_tx_head;
                  uart_start_transmit <= 1'b1;
                  r_state             <= START;
               end
            START: begin
               uart_start_transmit <= 1'b0;
               r_state             <= WAIT_BUSY;
            end
            WAIT_BUSY: if (!uart_tx_ready) r_state <= WAIT_DONE;
            WAIT_DONE: if (uart_tx_ready) r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
endmodule
